// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: element width, addressing mode and AGU state.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } vsew_t;

  typedef enum logic [1:0] {
    UNIT     = 2'b00,
    UINDEXED = 2'b01,
    STRIDED  = 2'b10,
    OINDEXED = 2'b11
  } mop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } agu_state_t;

  function automatic logic [31:0] eew_bytes(input vsew_t eew);
    case (eew)
      SEW8:    return 32'd1;
      SEW16:   return 32'd2;
      default: return 32'd4;
    endcase
  endfunction

  function automatic logic mop_is_indexed(input mop_t mop);
    return (mop == UINDEXED) || (mop == OINDEXED);
  endfunction

endpackage

// File: rtl/rv32v_vmem_byten.sv
// Word byte-enable generation and natural-alignment check for one element.
module rv32v_vmem_byten
  import rv32v_types_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  vsew_t      eew,
  output logic [3:0] byten,
  output logic       misaligned
);

  always_comb begin
    byten      = 4'hF;
    misaligned = 1'b0;
    case (eew)
      SEW8: begin
        byten = 4'b0001 << addr_lo;
      end
      SEW16: begin
        byten      = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: begin
        // Reserved encodings are handled like SEW32 so they can never issue unaligned.
        byten      = 4'hF;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/rv32v_vmem_agu.sv
// Vector load/store address generator: walks vl elements of one instruction,
// issuing one aligned word request per handshake and aborting on misalignment.
module rv32v_vmem_agu
  import rv32v_types_pkg::*;
#(
  parameter int VL_W = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [31:0]     base,
  input  logic [31:0]     stride,
  input  mop_t            mop,
  input  vsew_t           eew,
  input  logic [VL_W-1:0] vl,
  input  logic            is_store,
  input  logic            idx_valid,
  input  logic [31:0]     idx_data,
  output logic            idx_ready,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [31:0]     req_addr,
  output logic [3:0]      req_byten,
  output logic            req_wen,
  output logic [VL_W-1:0] req_elem,
  output logic            done,
  output logic            fault,
  output logic [VL_W-1:0] fault_elem,
  input  logic            kill
);

  agu_state_t      state;
  logic [VL_W-1:0] elem_q;
  logic [31:0]     acc_q;
  logic            fault_q;
  logic [VL_W-1:0] fault_elem_q;

  logic [31:0]     base_q;
  logic [31:0]     stride_q;
  mop_t            mop_q;
  vsew_t           eew_q;
  logic [VL_W-1:0] vl_q;
  logic            is_store_q;

  logic            accept;
  logic            indexed;
  logic            elem_present;
  logic            issuing;
  logic            misaligned;
  logic            fault_now;
  logic            handshake;
  logic            last_elem;
  logic [31:0]     cur_addr;
  logic [31:0]     step;
  logic [3:0]      byten;

  assign accept       = (state == IDLE) && start_valid && !kill;
  assign indexed      = mop_is_indexed(mop_q);
  assign elem_present = !indexed || idx_valid;
  assign cur_addr     = indexed ? (base_q + idx_data) : acc_q;
  assign step         = (mop_q == STRIDED) ? stride_q : eew_bytes(eew_q);
  assign last_elem    = (elem_q == (vl_q - VL_W'(1)));

  rv32v_vmem_byten u_byten (
    .addr_lo    (cur_addr[1:0]),
    .eew        (eew_q),
    .byten      (byten),
    .misaligned (misaligned)
  );

  // Kill masks the request in its own cycle so memory never sees a handshake
  // that the AGU is about to discard.
  assign issuing   = (state == ISSUE) && elem_present && !kill;
  assign req_valid = issuing && !misaligned;
  assign fault_now = issuing && misaligned;
  assign handshake = req_valid && req_ready;

  assign start_ready = (state == IDLE);
  assign idx_ready   = handshake;
  assign req_addr    = cur_addr;
  assign req_byten   = byten;
  assign req_wen     = is_store_q;
  assign req_elem    = elem_q;
  assign done        = (state == DONE);
  assign fault       = fault_q;
  assign fault_elem  = fault_elem_q;

  // Control state: FSM, element counter, address accumulator, fault reporting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      elem_q       <= '0;
      acc_q        <= '0;
      fault_q      <= 1'b0;
      fault_elem_q <= '0;
    end else begin
      fault_q <= 1'b0;
      if (kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_valid) begin
              elem_q       <= '0;
              acc_q        <= base;
              fault_elem_q <= '0;
              state        <= (vl == '0) ? DONE : ISSUE;
            end
          end
          ISSUE: begin
            if (fault_now) begin
              fault_q      <= 1'b1;
              fault_elem_q <= elem_q;
              state        <= IDLE;
            end else if (handshake) begin
              elem_q <= elem_q + VL_W'(1);
              acc_q  <= acc_q + step;
              if (last_elem) state <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Instruction operands: captured on accept, only meaningful while busy.
  always_ff @(posedge CLK) begin
    if (accept) begin
      base_q     <= base;
      stride_q   <= stride;
      mop_q      <= mop;
      eew_q      <= eew;
      vl_q       <= vl;
      is_store_q <= is_store;
    end
  end

endmodule
